// File: rtl/qpll_seq_pkg.sv
// Shared types and default timing for the QPLL0 reset sequencer.
package qpll_seq_pkg;

  // FSM state encodings; the numeric values are exposed on the status port.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ASSERT_RST = 3'd1,
    WAIT_LOCK  = 3'd2,
    STABLE     = 3'd3,
    READY      = 3'd4,
    FAIL       = 3'd5
  } qpll_seq_state_t;

  // Default timing and sizing for a real board.
  localparam int DEF_N_COMMON            = 2;
  localparam int DEF_RESET_HOLD_CYCLES   = 128;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  // Lock-loss counter saturates here rather than wrapping.
  localparam int LOCK_LOSS_MAX = 255;

  // Bit mask of the COMMONs that actually exist; any value other than 1 means both.
  function automatic logic [1:0] active_mask(input int n_common);
    return (n_common == 1) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing asynchronous level signals into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; the second stage gives it a full cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qpll_reset_sequencer.sv
// Power-up / recovery sequencer for the shared GTYE4_COMMON QPLL0s feeding the CMAC GTs.
// Pulses qpll0reset, waits for qualified lock with timeout and bounded retries, and
// holds the downstream GT/CMAC reset until the PLLs are usable.
module qpll_reset_sequencer
  import qpll_seq_pkg::*;
#(
  parameter int N_COMMON            = DEF_N_COMMON,
  parameter int RESET_HOLD_CYCLES   = DEF_RESET_HOLD_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] qpll0reset,
  input  logic [1:0] qpll0lock,
  output logic       pll_ready,
  output logic       gt_reset_req,
  output logic       fail,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  localparam logic [1:0] ACTIVE_MASK = active_mask(N_COMMON);

  localparam int HOLD_W    = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

  // Terminal values: each counter starts at zero on entry to its phase, so the phase
  // ends on the cycle the counter shows max-1.
  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);
  localparam logic [7:0]           LOSS_MAX     = 8'(LOCK_LOSS_MAX);

  qpll_seq_state_t state_q, state_d;

  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [STABLE_W-1:0]  stable_q, stable_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [7:0]           loss_q, loss_d;

  logic [1:0] qpll0reset_d;
  logic       pll_ready_d;
  logic       gt_reset_req_d;
  logic       fail_d;

  logic [1:0] lock_sync;
  logic       all_locked;

  // Raw lock comes from the QPLL domain (or no clock at all while unlocked).
  sync_2ff #(
    .WIDTH(2)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (qpll0lock),
    .q   (lock_sync)
  );

  // Absent COMMONs are forced to "locked" so they never block the AND.
  assign all_locked = &(lock_sync | ~ACTIVE_MASK);

  // Next-state, counter and output decode for the sequencer.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    stable_d  = stable_q;
    retry_d   = retry_q;
    loss_d    = loss_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ASSERT_RST;
          retry_d = '0;
          hold_d  = '0;
        end
      end

      ASSERT_RST: begin
        if (hold_q == HOLD_LAST) begin
          state_d   = WAIT_LOCK;
          timeout_d = '0;
          stable_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      WAIT_LOCK, STABLE: begin
        // The timeout spans both phases, so a flapping lock cannot stall forever.
        if (timeout_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LAST) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ASSERT_RST;
            hold_d  = '0;
          end
        end else begin
          timeout_d = timeout_q + TIMEOUT_W'(1);
          if (state_q == WAIT_LOCK) begin
            if (all_locked) begin
              state_d  = STABLE;
              stable_d = '0;
            end
          end else if (!all_locked) begin
            state_d  = WAIT_LOCK;
            stable_d = '0;
          end else if (stable_q == STABLE_LAST) begin
            state_d = READY;
          end else begin
            stable_d = stable_q + STABLE_W'(1);
          end
        end
      end

      READY: begin
        if (!all_locked) begin
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + 8'd1;
          end
          retry_d = '0;
          state_d = ASSERT_RST;
          hold_d  = '0;
        end
      end

      FAIL: begin
        if (start) begin
          state_d = ASSERT_RST;
          retry_d = '0;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A software restart mid-sequence overrides everything except the lock-loss tally,
    // which the READY branch above may already have bumped this cycle.
    if (start && (state_q != IDLE) && (state_q != FAIL)) begin
      state_d   = ASSERT_RST;
      retry_d   = '0;
      hold_d    = '0;
      timeout_d = '0;
      stable_d  = '0;
    end

    qpll0reset_d   = (state_d == ASSERT_RST) ? ACTIVE_MASK : 2'b00;
    pll_ready_d    = (state_d == READY);
    gt_reset_req_d = (state_d != READY);
    fail_d         = (state_d == FAIL);
  end

  // State, counters and registered outputs all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      timeout_q    <= '0;
      stable_q     <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      qpll0reset   <= 2'b00;
      pll_ready    <= 1'b0;
      gt_reset_req <= 1'b1;
      fail         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      timeout_q    <= timeout_d;
      stable_q     <= stable_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      qpll0reset   <= qpll0reset_d;
      pll_ready    <= pll_ready_d;
      gt_reset_req <= gt_reset_req_d;
      fail         <= fail_d;
    end
  end

  assign retry_count     = 2'(retry_q);
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule
